fetch_stage_ctrl: RTL and testbench
===================================

Name: fetch_stage_ctrl

Overview:
Owns the PC register and the IF/ID pipeline register of the 5-stage MIPS core. It is the consumer of the hazard detection unit's Stall output: it holds the front end on Stall and redirects on branches/jumps resolved in ID. It runs the fetch handshake with instruction memory and counts front-end stall cycles.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
NOP_INSTR, 32'h0000_0000, instruction word injected into IF/ID on flush/bubble

Ports:
clk  input  1  core clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
Stall  input  1  load-use or branch-operand hazard from hazard unit; hold PC and IF/ID
Freeze  input  1  global freeze (D-cache miss); no state changes at all
BranchTaken  input  1  branch in ID resolved taken
BranchTarget  input  32  branch target
Jump  input  1  jump in ID
JumpTarget  input  32  jump target
IMemStall  input  1  instruction memory not ready this cycle
IMemRdata  input  32  instruction word; valid when IMemRead=1 and IMemStall=0
IMemRead  output  1  fetch request
IMemAddr  output  32  fetch address (= PC)
IfIdPC  output  32  PC+4 of instruction in IF/ID
IfIdInstr  output  32  instruction in IF/ID
IfIdValid  output  1  IF/ID holds a real instruction
StallCount  output  32  cycles in which PC did not advance (excluding reset)

Behaviour:
- Reset (rst=1 at edge): PC=RESET_PC, IfIdInstr=NOP_INSTR, IfIdPC=0, IfIdValid=0, StallCount=0, state=FETCH, pending target=0. IMemRead=0 while rst=1, otherwise 1. IMemAddr=PC always. Reset overrides everything, including mid-handshake.
- Redirect = BranchTaken|Jump; Target = JumpTarget if Jump, else BranchTarget (Jump wins if both set).
- Priority per edge: rst > Freeze > Stall > redirect > normal advance.
- Freeze=1: PC, IF/ID, state and StallCount are all unchanged.
- State FETCH:
  - Stall=1: PC and IF/ID hold; redirect ignored, since branch operands are not ready and the hazard unit reasserts later.
  - Stall=0, redirect=1, IMemStall=0: PC<=Target; IF/ID<=NOP_INSTR, IfIdValid=0, IfIdPC=0. The fetched word is squashed.
  - Stall=0, redirect=1, IMemStall=1: latch Target into the pending register; IF/ID<=bubble; go to DISCARD.
  - Stall=0, redirect=0, IMemStall=0: PC<=PC+4; IfIdInstr<=IMemRdata, IfIdPC<=PC+4, IfIdValid=1.
  - Stall=0, redirect=0, IMemStall=1: PC holds; IF/ID<=bubble, because ID has consumed the old instruction.
- State DISCARD (wrong-path fetch in flight): IMemAddr still presents the old PC, so the handshake is not abandoned.
  - IMemStall=1: hold; IF/ID stays bubble.
  - IMemStall=0: drop IMemRdata; PC<=pending; go to FETCH.
  - A new redirect in DISCARD with Stall=0 overwrites the pending target (the latest wins).
  - Stall is ignored for the PC in DISCARD; IF/ID keeps its bubble.
- Latency: the instruction at address A appears in IF/ID on the edge after the first cycle with IMemAddr=A and IMemStall=0 and no stall/redirect.
- PC arithmetic is 32-bit modulo: PC 32'hFFFF_FFFC + 4 wraps to 0. Bits [1:0] of targets pass through unchecked.
- StallCount increments on each non-reset, non-Freeze cycle in which PC does not change (Stall, IMemStall, or DISCARD wait). It wraps at 2^32-1 -> 0.

Test Plan:
- Reset then free-run with IMemStall=0, memory returns addr-as-data: IfIdInstr sequence 0,4,8,... with IfIdPC 4,8,12; IfIdValid=1 from the second cycle; StallCount=0.
- Stall=1 for 2 cycles with IF/ID holding PC 8's instruction: IfIdInstr unchanged, IMemAddr=12 held, StallCount=2. Then resumes with 12.
- BranchTaken=1, BranchTarget=0x100 with IMemStall=0: next cycle IMemAddr=0x100, IfIdValid=0; the following cycle IfIdInstr=0x100.
- Jump to 0x200 while IMemStall=1 for 3 cycles: DISCARD entered; the stale word is never visible (IfIdValid=0 throughout); IMemAddr=0x200 the cycle after IMemStall falls.
- Stall=1 and BranchTaken=1 together: PC holds, no redirect. Freeze=1 with Stall=1 and redirect: nothing changes and StallCount is frozen.
- rst asserted in DISCARD: next cycle PC=RESET_PC, state FETCH, pending target discarded, all outputs at reset values.

Source files
------------

// File: rtl/fetch_stage_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fetch_stage_ctrl : PC register, IF/ID register and instruction-fetch handshake
// Revision 1.0
// ---------------------------------------------------------------------------
module fetch_stage_ctrl #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        Stall,
   input  logic        Freeze,
   input  logic        BranchTaken,
   input  logic [31:0] BranchTarget,
   input  logic        Jump,
   input  logic [31:0] JumpTarget,
   input  logic        IMemStall,
   input  logic [31:0] IMemRdata,
   output logic        IMemRead,
   output logic [31:0] IMemAddr,
   output logic [31:0] IfIdPC,
   output logic [31:0] IfIdInstr,
   output logic        IfIdValid,
   output logic [31:0] StallCount
);

   localparam logic [0:0] ST_FETCH   = 1'b0;
   localparam logic [0:0] ST_DISCARD = 1'b1;

   logic [0:0]  state, state_next;
   logic [31:0] pc, pc_next;
   logic [31:0] pending, pending_next;
   logic [31:0] ifid_pc_next, ifid_instr_next;
   logic        ifid_valid_next;
   logic [31:0] stall_count_next;

   logic        redirect;
   logic [31:0] target;
   logic [31:0] pc_plus4;

   assign redirect = BranchTaken | Jump;
   assign target   = Jump ? JumpTarget : BranchTarget;
   assign pc_plus4 = pc + 32'd4;

   // State and datapath register
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_FETCH;
         pc         <= RESET_PC;
         pending    <= 32'd0;
         IfIdPC     <= 32'd0;
         IfIdInstr  <= NOP_INSTR;
         IfIdValid  <= 1'b0;
         StallCount <= 32'd0;
      end else begin
         state      <= state_next;
         pc         <= pc_next;
         pending    <= pending_next;
         IfIdPC     <= ifid_pc_next;
         IfIdInstr  <= ifid_instr_next;
         IfIdValid  <= ifid_valid_next;
         StallCount <= stall_count_next;
      end
   end

   // Next-state logic
   always_comb begin
      state_next = state;
      if (!Freeze) begin
         case (state)
            ST_FETCH:   if (!Stall && redirect && IMemStall) state_next = ST_DISCARD;
            ST_DISCARD: if (!IMemStall) state_next = ST_FETCH;
            default:    state_next = ST_FETCH;
         endcase
      end
   end

   // Datapath next values; a bubble is written whenever IF/ID cannot take a real word
   always_comb begin
      pc_next          = pc;
      pending_next     = pending;
      ifid_pc_next     = IfIdPC;
      ifid_instr_next  = IfIdInstr;
      ifid_valid_next  = IfIdValid;
      stall_count_next = StallCount;
      if (!Freeze) begin
         case (state)
            ST_FETCH: begin
               if (Stall) begin
                  stall_count_next = StallCount + 32'd1;
               end else if (redirect) begin
                  ifid_pc_next    = 32'd0;
                  ifid_instr_next = NOP_INSTR;
                  ifid_valid_next = 1'b0;
                  if (!IMemStall) begin
                     pc_next = target;
                  end else begin
                     pending_next     = target;
                     stall_count_next = StallCount + 32'd1;
                  end
               end else if (!IMemStall) begin
                  pc_next         = pc_plus4;
                  ifid_pc_next    = pc_plus4;
                  ifid_instr_next = IMemRdata;
                  ifid_valid_next = 1'b1;
               end else begin
                  ifid_pc_next     = 32'd0;
                  ifid_instr_next  = NOP_INSTR;
                  ifid_valid_next  = 1'b0;
                  stall_count_next = StallCount + 32'd1;
               end
            end
            default: begin
               ifid_pc_next    = 32'd0;
               ifid_instr_next = NOP_INSTR;
               ifid_valid_next = 1'b0;
               if (redirect && !Stall) pending_next = target;
               if (IMemStall) begin
                  stall_count_next = StallCount + 32'd1;
               end else begin
                  // Wrong-path word is dropped; the most recent redirect wins
                  pc_next = (redirect && !Stall) ? target : pending;
               end
            end
         endcase
      end
   end

   // Fetch handshake outputs
   always_comb begin
      IMemRead = ~rst;
      IMemAddr = pc;
   end

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage_ctrl.sv
`default_nettype none
// Testbench for fetch_stage_ctrl: scenario tasks with a queue of expected post-edge observations.
module tb_fetch_stage_ctrl;

   logic        clk = 1'b0;
   logic        rst, Stall, Freeze, BranchTaken, Jump, IMemStall;
   logic [31:0] BranchTarget, JumpTarget, IMemRdata;
   logic        IMemRead, IfIdValid;
   logic [31:0] IMemAddr, IfIdPC, IfIdInstr, StallCount;

   int tests_run = 0;
   int tests_failed = 0;

   typedef struct packed {
      logic        rd;
      logic [31:0] addr;
      logic [31:0] ipc;
      logic [31:0] instr;
      logic        valid;
      logic [31:0] cnt;
   } obs_t;

   typedef struct packed {
      logic        rst;
      logic        stall;
      logic        freeze;
      logic        br;
      logic [31:0] bt;
      logic        j;
      logic [31:0] jt;
      logic        ims;
   } step_t;

   obs_t exp_q[$];

   fetch_stage_ctrl dut (
      .clk(clk), .rst(rst), .Stall(Stall), .Freeze(Freeze),
      .BranchTaken(BranchTaken), .BranchTarget(BranchTarget),
      .Jump(Jump), .JumpTarget(JumpTarget),
      .IMemStall(IMemStall), .IMemRdata(IMemRdata),
      .IMemRead(IMemRead), .IMemAddr(IMemAddr),
      .IfIdPC(IfIdPC), .IfIdInstr(IfIdInstr), .IfIdValid(IfIdValid),
      .StallCount(StallCount)
   );

   always #5 clk = ~clk;

   // Instruction memory returns its address as data
   assign IMemRdata = IMemAddr;

   task automatic drive(input step_t s);
      @(negedge clk);
      rst = s.rst; Stall = s.stall; Freeze = s.freeze;
      BranchTaken = s.br; BranchTarget = s.bt; Jump = s.j; JumpTarget = s.jt;
      IMemStall = s.ims;
      @(posedge clk);
      #1;
   endtask

   function automatic obs_t sample();
      return '{rd: IMemRead, addr: IMemAddr, ipc: IfIdPC, instr: IfIdInstr,
               valid: IfIdValid, cnt: StallCount};
   endfunction

   function automatic step_t nrm(input logic ims);
      return '{rst: 1'b0, stall: 1'b0, freeze: 1'b0, br: 1'b0, bt: 32'd0,
               j: 1'b0, jt: 32'd0, ims: ims};
   endfunction

   function automatic obs_t ob(input logic [31:0] addr, input logic [31:0] ipc,
                               input logic [31:0] instr, input logic valid,
                               input logic [31:0] cnt);
      return '{rd: 1'b1, addr: addr, ipc: ipc, instr: instr, valid: valid, cnt: cnt};
   endfunction

   task automatic test_reset();
      step_t s;
      obs_t  got, ex;
      s = nrm(1'b0);
      s.rst = 1'b1;
      for (int i = 0; i < 2; i++) begin
         exp_q.push_back('{rd: 1'b0, addr: 32'd0, ipc: 32'd0, instr: 32'd0, valid: 1'b0, cnt: 32'd0});
         drive(s);
         got = sample();
         ex = exp_q.pop_front();
         tests_run++;
         if (got !== ex) begin
            tests_failed++;
            $display("FAIL reset[%0d] got %p expected %p", i, got, ex);
         end
      end
   endtask

   task automatic test_free_run();
      obs_t got, ex;
      for (int k = 1; k <= 3; k++) begin
         exp_q.push_back(ob(32'(4*k), 32'(4*k), 32'(4*(k-1)), 1'b1, 32'd0));
         drive(nrm(1'b0));
         got = sample();
         ex = exp_q.pop_front();
         tests_run++;
         if (got !== ex) begin
            tests_failed++;
            $display("FAIL free_run[%0d] got %p expected %p", k, got, ex);
         end
      end
   endtask

   task automatic test_stall();
      step_t s[3];
      obs_t  e[3];
      obs_t  got, ex;
      s[0] = nrm(1'b0); s[0].stall = 1'b1;
      s[1] = s[0];
      s[2] = nrm(1'b0);
      e[0] = ob(32'd12, 32'd12, 32'd8, 1'b1, 32'd1);
      e[1] = ob(32'd12, 32'd12, 32'd8, 1'b1, 32'd2);
      e[2] = ob(32'd16, 32'd16, 32'd12, 1'b1, 32'd2);
      for (int i = 0; i < 3; i++) begin
         exp_q.push_back(e[i]);
         drive(s[i]);
         got = sample();
         ex = exp_q.pop_front();
         tests_run++;
         if (got !== ex) begin
            tests_failed++;
            $display("FAIL stall[%0d] got %p expected %p", i, got, ex);
         end
      end
   endtask

   task automatic test_branch();
      step_t s[2];
      obs_t  e[2];
      obs_t  got, ex;
      s[0] = nrm(1'b0); s[0].br = 1'b1; s[0].bt = 32'h100;
      s[1] = nrm(1'b0);
      e[0] = ob(32'h100, 32'h0, 32'h0, 1'b0, 32'd2);
      e[1] = ob(32'h104, 32'h104, 32'h100, 1'b1, 32'd2);
      for (int i = 0; i < 2; i++) begin
         exp_q.push_back(e[i]);
         drive(s[i]);
         got = sample();
         ex = exp_q.pop_front();
         tests_run++;
         if (got !== ex) begin
            tests_failed++;
            $display("FAIL branch[%0d] got %p expected %p", i, got, ex);
         end
      end
   endtask

   task automatic test_jump_discard();
      step_t s[5];
      obs_t  e[5];
      obs_t  got, ex;
      s[0] = nrm(1'b1); s[0].j = 1'b1; s[0].jt = 32'h200;
      s[1] = nrm(1'b1);
      s[2] = nrm(1'b1);
      s[3] = nrm(1'b0);
      s[4] = nrm(1'b0);
      e[0] = ob(32'h104, 32'h0, 32'h0, 1'b0, 32'd3);
      e[1] = ob(32'h104, 32'h0, 32'h0, 1'b0, 32'd4);
      e[2] = ob(32'h104, 32'h0, 32'h0, 1'b0, 32'd5);
      e[3] = ob(32'h200, 32'h0, 32'h0, 1'b0, 32'd5);
      e[4] = ob(32'h204, 32'h204, 32'h200, 1'b1, 32'd5);
      for (int i = 0; i < 5; i++) begin
         exp_q.push_back(e[i]);
         drive(s[i]);
         got = sample();
         ex = exp_q.pop_front();
         tests_run++;
         if (got !== ex) begin
            tests_failed++;
            $display("FAIL jump_discard[%0d] got %p expected %p", i, got, ex);
         end
      end
   endtask

   task automatic test_discard_retarget();
      step_t s[4];
      obs_t  e[4];
      obs_t  got, ex;
      s[0] = nrm(1'b1); s[0].j = 1'b1; s[0].jt = 32'h400;
      s[1] = nrm(1'b1); s[1].br = 1'b1; s[1].bt = 32'h500;
      s[2] = nrm(1'b0);
      s[3] = nrm(1'b0);
      e[0] = ob(32'h204, 32'h0, 32'h0, 1'b0, 32'd6);
      e[1] = ob(32'h204, 32'h0, 32'h0, 1'b0, 32'd7);
      e[2] = ob(32'h500, 32'h0, 32'h0, 1'b0, 32'd7);
      e[3] = ob(32'h504, 32'h504, 32'h500, 1'b1, 32'd7);
      for (int i = 0; i < 4; i++) begin
         exp_q.push_back(e[i]);
         drive(s[i]);
         got = sample();
         ex = exp_q.pop_front();
         tests_run++;
         if (got !== ex) begin
            tests_failed++;
            $display("FAIL discard_retarget[%0d] got %p expected %p", i, got, ex);
         end
      end
   endtask

   task automatic test_stall_freeze();
      step_t s[4];
      obs_t  e[4];
      obs_t  got, ex;
      s[0] = nrm(1'b0); s[0].stall = 1'b1; s[0].br = 1'b1; s[0].bt = 32'h800;
      s[1] = s[0]; s[1].freeze = 1'b1; s[1].j = 1'b1; s[1].jt = 32'h900;
      s[2] = nrm(1'b1); s[2].freeze = 1'b1;
      s[3] = nrm(1'b0);
      e[0] = ob(32'h504, 32'h504, 32'h500, 1'b1, 32'd8);
      e[1] = e[0];
      e[2] = e[0];
      e[3] = ob(32'h508, 32'h508, 32'h504, 1'b1, 32'd8);
      for (int i = 0; i < 4; i++) begin
         exp_q.push_back(e[i]);
         drive(s[i]);
         got = sample();
         ex = exp_q.pop_front();
         tests_run++;
         if (got !== ex) begin
            tests_failed++;
            $display("FAIL stall_freeze[%0d] got %p expected %p", i, got, ex);
         end
      end
   endtask

   task automatic test_imem_stall();
      step_t s[2];
      obs_t  e[2];
      obs_t  got, ex;
      s[0] = nrm(1'b1);
      s[1] = nrm(1'b0);
      e[0] = ob(32'h508, 32'h0, 32'h0, 1'b0, 32'd9);
      e[1] = ob(32'h50C, 32'h50C, 32'h508, 1'b1, 32'd9);
      for (int i = 0; i < 2; i++) begin
         exp_q.push_back(e[i]);
         drive(s[i]);
         got = sample();
         ex = exp_q.pop_front();
         tests_run++;
         if (got !== ex) begin
            tests_failed++;
            $display("FAIL imem_stall[%0d] got %p expected %p", i, got, ex);
         end
      end
   endtask

   task automatic test_reset_in_discard();
      step_t s[3];
      obs_t  e[3];
      obs_t  got, ex;
      s[0] = nrm(1'b1); s[0].j = 1'b1; s[0].jt = 32'h900;
      s[1] = nrm(1'b0); s[1].rst = 1'b1;
      s[2] = nrm(1'b0);
      e[0] = ob(32'h50C, 32'h0, 32'h0, 1'b0, 32'd10);
      e[1] = '{rd: 1'b0, addr: 32'd0, ipc: 32'd0, instr: 32'd0, valid: 1'b0, cnt: 32'd0};
      e[2] = ob(32'h4, 32'h4, 32'h0, 1'b1, 32'd0);
      for (int i = 0; i < 3; i++) begin
         exp_q.push_back(e[i]);
         drive(s[i]);
         got = sample();
         ex = exp_q.pop_front();
         tests_run++;
         if (got !== ex) begin
            tests_failed++;
            $display("FAIL reset_in_discard[%0d] got %p expected %p", i, got, ex);
         end
      end
   endtask

   task automatic test_pc_wrap();
      step_t s[3];
      obs_t  e[3];
      obs_t  got, ex;
      s[0] = nrm(1'b0); s[0].j = 1'b1; s[0].jt = 32'hFFFF_FFFC;
      s[1] = nrm(1'b0);
      s[2] = nrm(1'b0);
      e[0] = ob(32'hFFFF_FFFC, 32'h0, 32'h0, 1'b0, 32'd0);
      e[1] = ob(32'h0, 32'h0, 32'hFFFF_FFFC, 1'b1, 32'd0);
      e[2] = ob(32'h4, 32'h4, 32'h0, 1'b1, 32'd0);
      for (int i = 0; i < 3; i++) begin
         exp_q.push_back(e[i]);
         drive(s[i]);
         got = sample();
         ex = exp_q.pop_front();
         tests_run++;
         if (got !== ex) begin
            tests_failed++;
            $display("FAIL pc_wrap[%0d] got %p expected %p", i, got, ex);
         end
      end
   endtask

   initial begin
      rst = 1'b1; Stall = 1'b0; Freeze = 1'b0; BranchTaken = 1'b0; Jump = 1'b0;
      BranchTarget = 32'd0; JumpTarget = 32'd0; IMemStall = 1'b0;
      test_reset();
      test_free_run();
      test_stall();
      test_branch();
      test_jump_discard();
      test_discard_retarget();
      test_stall_freeze();
      test_imem_stall();
      test_reset_in_discard();
      test_pc_wrap();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
`default_nettype wire
